// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - shared types and encodings for the system-bus memory
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - synchronous single-port 16-bit RAM, registered read
module mem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  // Read-before-write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sysbus_mem.sv
// rtl/sysbus_mem.sv - wait-state memory slave on a multiplexed address/data bus
module sysbus_mem
  import sysbus_pkg::*;
#(
  parameter int AW          = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] SysBus,
  input  logic        Ale,
  input  logic        Req,
  input  logic        Rw,
  output logic [15:0] DataIn,
  output logic        Ready,
  output logic        Fault
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        rw_q;
  logic [3:0]  cnt_q;
  logic [15:0] ram_rdata;
  logic        accept;
  logic        oor;
  logic        finish;
  logic        ram_we;

  assign accept = (state == IDLE) && Req && !Ale;
  assign oor    = |(addr_q >> AW);
  assign finish = (state == DONE);
  // The array is written on the DONE->IDLE edge, the same edge that raises Ready.
  assign ram_we = finish && (rw_q == RW_WRITE) && !oor;

  mem_array #(.AW(AW)) u_mem (
    .clk   (Clock),
    .we    (ram_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? DONE : WAIT;
      WAIT: if (cnt_q <= 4'd1) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rw_q    <= RW_READ;
      cnt_q   <= 4'd0;
      Ready   <= 1'b0;
      Fault   <= 1'b0;
      DataIn  <= 16'h0000;
    end else begin
      if (state == IDLE && Ale) begin
        addr_q <= SysBus;
      end
      if (accept) begin
        rw_q <= Rw;
        if (Rw == RW_WRITE) begin
          wdata_q <= SysBus;
        end
      end
      if (accept) begin
        cnt_q <= 4'(WAIT_STATES);
      end else if (state == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      Ready <= finish;
      // ram_rdata already reflects addr_q while in DONE.
      if (finish) begin
        Fault <= oor;
        if (rw_q == RW_READ) begin
          DataIn <= oor ? 16'h0000 : ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysbus_mem.sv
// tb/tb_sysbus_mem.sv - two-instance randomized and directed bench with behavioural model
module tb_sysbus_mem;

  localparam int WS0 = 0;
  localparam int WS1 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus;
  logic        ale, req, rw;
  logic [1:0]  rdy, flt;
  logic [15:0] dat0, dat1;
  logic [15:0] dat [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dat[0] = dat0;
  assign dat[1] = dat1;

  sysbus_mem #(.AW(8), .WAIT_STATES(WS0)) dut0 (
    .Clock(clk), .nReset(rst_n), .SysBus(bus), .Ale(ale), .Req(req), .Rw(rw),
    .DataIn(dat0), .Ready(rdy[0]), .Fault(flt[0])
  );

  sysbus_mem #(.AW(8), .WAIT_STATES(WS1)) dut1 (
    .Clock(clk), .nReset(rst_n), .SysBus(bus), .Ale(ale), .Req(req), .Rw(rw),
    .DataIn(dat1), .Ready(rdy[1]), .Fault(flt[1])
  );

  // Behavioural model: an access accepted at edge t completes at edge t+1+WS.
  logic [15:0] mmem   [2][256];
  bit          mknown [2][256];
  bit          m_busy [2];
  int          m_rem  [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wd   [2];
  logic        m_rw   [2];
  logic        exp_rdy [2];
  logic        exp_flt [2];
  logic [15:0] exp_data [2];
  bit          exp_known [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_rem[i] = 0; m_addr[i] = 16'h0000;
        exp_rdy[i] = 1'b0; exp_flt[i] = 1'b0; exp_data[i] = 16'h0000; exp_known[i] = 1;
      end else if (m_busy[i]) begin
        exp_rdy[i] = 1'b0;
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_busy[i]  = 0;
          exp_rdy[i] = 1'b1;
          exp_flt[i] = (m_addr[i] > 16'h00FF);
          if (m_rw[i]) begin
            if (exp_flt[i]) begin
              exp_data[i] = 16'h0000; exp_known[i] = 1;
            end else begin
              exp_data[i] = mmem[i][m_addr[i][7:0]]; exp_known[i] = mknown[i][m_addr[i][7:0]];
            end
          end else if (!exp_flt[i]) begin
            mmem[i][m_addr[i][7:0]] = m_wd[i]; mknown[i][m_addr[i][7:0]] = 1;
          end
        end
      end else begin
        exp_rdy[i] = 1'b0;
        if (ale) m_addr[i] = bus;
        else if (req) begin
          m_busy[i] = 1; m_rem[i] = 1 + ((i == 0) ? WS0 : WS1); m_rw[i] = rw; m_wd[i] = bus;
        end
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s[dut%0d] actual=%h required=%h at %0t", name, idx, act, req_v, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("cyc_ready", i, 16'(rdy[i]), 16'(exp_rdy[i]));
      chk("cyc_fault", i, 16'(flt[i]), 16'(exp_flt[i]));
      if (exp_known[i]) chk("cyc_data", i, dat[i], exp_data[i]);
    end
  end

  task automatic ale_cycle(input logic [15:0] a);
    ale = 1'b1; req = 1'b0; bus = a;
    @(negedge clk); #1;
    ale = 1'b0;
  endtask

  task automatic access(input logic r, input logic [15:0] d, input logic [15:0] e0,
                        input logic [15:0] e1, input logic efault, input string nm);
    int lat [2];
    int cnt [2];
    lat = '{0, 0}; cnt = '{0, 0};
    req = 1'b1; rw = r; bus = d; ale = 1'b0;
    @(negedge clk); #1;
    req = 1'b0; bus = 16'($urandom);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) if (rdy[i]) begin
        cnt[i]++;
        if (lat[i] == 0) lat[i] = k;
      end
    end
    chk({nm, "_lat"}, 0, 16'(lat[0]), 16'd1);
    chk({nm, "_lat"}, 1, 16'(lat[1]), 16'd3);
    chk({nm, "_nready"}, 0, 16'(cnt[0]), 16'd1);
    chk({nm, "_nready"}, 1, 16'(cnt[1]), 16'd1);
    chk({nm, "_fault"}, 0, 16'(flt[0]), 16'(efault));
    chk({nm, "_fault"}, 1, 16'(flt[1]), 16'(efault));
    chk({nm, "_data"}, 0, dat[0], e0);
    chk({nm, "_data"}, 1, dat[1], e1);
  endtask

  initial begin
    logic [11:0] pat [2];
    int nrdy [2];
    int lat1;
    rst_n = 1'b0; ale = 1'b0; req = 1'b0; rw = 1'b0; bus = 16'h0000;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 16'(rdy[i]), 16'd0);
      chk("rst_fault", i, 16'(flt[i]), 16'd0);
      chk("rst_data", i, dat[i], 16'h0000);
    end

    // Write then read back 0x0012.
    ale_cycle(16'h0012);
    access(1'b0, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, "wr12");
    ale_cycle(16'h0012);
    access(1'b1, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, "rd12");

    // Back-to-back reads with Req held high.
    ale_cycle(16'h0005);
    access(1'b0, 16'h4242, 16'hBEEF, 16'hBEEF, 1'b0, "wr05");
    ale_cycle(16'h0005);
    pat = '{12'h000, 12'h000};
    req = 1'b1; rw = 1'b1; bus = 16'h0000;
    @(negedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) pat[i][k-1] = rdy[i];
    end
    req = 1'b0;
    chk("b2b_pattern", 0, 16'(pat[0]), 16'h0555);
    chk("b2b_pattern", 1, 16'(pat[1]), 16'h0444);
    repeat (6) @(negedge clk); #1;
    chk("b2b_data", 0, dat[0], 16'h4242);
    chk("b2b_data", 1, dat[1], 16'h4242);

    // Out-of-range write must not alias onto word 0.
    ale_cycle(16'h0000);
    access(1'b0, 16'h1111, 16'h4242, 16'h4242, 1'b0, "wr00");
    ale_cycle(16'h0100);
    access(1'b0, 16'h1234, 16'h4242, 16'h4242, 1'b1, "wr_oor");
    access(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, "rd_oor");
    ale_cycle(16'h0000);
    access(1'b1, 16'h0000, 16'h1111, 16'h1111, 1'b0, "rd00");

    // Ale and Req together: address latched, no access.
    ale_cycle(16'h0033);
    access(1'b0, 16'hC0DE, 16'h1111, 16'h1111, 1'b0, "wr33");
    ale_cycle(16'h0012);
    ale = 1'b1; req = 1'b1; rw = 1'b1; bus = 16'h0033;
    @(negedge clk); #1;
    ale = 1'b0; req = 1'b0;
    nrdy = '{0, 0};
    repeat (5) begin
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) if (rdy[i]) nrdy[i]++;
    end
    chk("alereq_noready", 0, 16'(nrdy[0]), 16'd0);
    chk("alereq_noready", 1, 16'(nrdy[1]), 16'd0);
    access(1'b1, 16'h0012, 16'hC0DE, 16'hC0DE, 1'b0, "rd33");

    // Reset in the middle of a write.
    ale_cycle(16'h0007);
    access(1'b0, 16'h5555, 16'hC0DE, 16'hC0DE, 1'b0, "wr07");
    ale_cycle(16'h0007);
    req = 1'b1; rw = 1'b0; bus = 16'hAAAA;
    @(negedge clk); #1;
    req = 1'b0; rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("abort_ready", i, 16'(rdy[i]), 16'd0);
      chk("abort_fault", i, 16'(flt[i]), 16'd0);
      chk("abort_data", i, dat[i], 16'h0000);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    nrdy = '{0, 0};
    repeat (6) begin
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) if (rdy[i]) nrdy[i]++;
    end
    chk("abort_noready", 0, 16'(nrdy[0]), 16'd0);
    chk("abort_noready", 1, 16'(nrdy[1]), 16'd0);
    ale_cycle(16'h0007);
    access(1'b1, 16'h0000, 16'h5555, 16'h5555, 1'b0, "rd07");

    // Bus activity while the slow instance waits.
    ale_cycle(16'h0012);
    req = 1'b1; rw = 1'b0; bus = 16'h7777;
    @(negedge clk); #1;
    lat1 = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) begin req = 1'b0; ale = 1'b1; bus = 16'h0033; end
      else if (k == 2) begin ale = 1'b0; req = 1'b1; rw = 1'b0; bus = 16'h5A5A; end
      else begin ale = 1'b0; req = 1'b0; end
      @(negedge clk); #1;
      if (rdy[1] && lat1 == 0) lat1 = k;
    end
    chk("disturb_lat", 1, 16'(lat1), 16'd3);
    ale_cycle(16'h0012);
    access(1'b1, 16'h0000, 16'h5A5A, 16'h7777, 1'b0, "rd_disturb");

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      ale = ($urandom_range(0, 5) == 0);
      req = ($urandom_range(0, 2) == 0);
      rw  = 1'($urandom_range(0, 1));
      if (ale)
        bus = ($urandom_range(0, 7) == 0) ? (16'h0100 | 16'($urandom_range(0, 255)))
                                          : 16'($urandom_range(0, 15));
      else
        bus = 16'($urandom);
      @(negedge clk); #1;
    end
    rst_n = 1'b1; ale = 1'b0; req = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysbus_mem.md
SYSBUS_MEM -- requirements
Module: sysbus_mem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them (Clock, nReset).
REQ-002 The block SHALL have these parameters:
- AW, 8: word-address width of the internal array (depth 2^AW 16-bit words).
- WAIT_STATES, 2: extra cycles inserted before Ready (legal range 0..15).
REQ-003 The block SHALL have these ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- SysBus  in  16  processor bus; carries the address when Ale=1 and write data when Req=1 with Rw=0.
- Ale  in  1  address latch enable.
- Req  in  1  access request.
- Rw  in  1  access type: 1 = read, 0 = write.
- DataIn  out  16  read data returned to the processor datapath.
- Ready  out  1  one-cycle access-complete strobe.
- Fault  out  1  last access was out of range.

Function
REQ-004 In IDLE, Ale=1 SHALL latch SysBus into the 16-bit address register at the clock edge.
REQ-005 In IDLE, Req=1 with Ale=0 SHALL start an access, capture Rw, and (for writes) capture SysBus as write data at that edge.
REQ-006 Req=1 and Ale=1 in the same cycle SHALL latch the address only; no access starts.
REQ-007 The FSM SHALL have three states:
- IDLE
- WAIT: down-counter loaded with WAIT_STATES
- DONE
REQ-008 The FSM transitions SHALL be:
- IDLE -> WAIT on an accepted Req when WAIT_STATES>0.
- IDLE -> DONE on an accepted Req when WAIT_STATES=0.
- WAIT -> DONE when the counter reaches 0; otherwise the counter decrements each cycle.
- DONE -> IDLE unconditionally.
REQ-009 For a Req accepted at edge t, Ready SHALL be 1 for exactly the one cycle following edge t+1+WAIT_STATES, and 0 at all other times.
REQ-010 Read: DataIn SHALL update at the same edge that raises Ready and hold until the next completed read.
REQ-011 Write: the array SHALL be updated at the edge that raises Ready; DataIn SHALL be unchanged by a write.
REQ-012 Out of range is any address with bits [15:AW] nonzero. Such a read SHALL return 16'h0000, such a write SHALL be discarded, and Fault SHALL be set at the Ready edge.
REQ-013 Fault SHALL be cleared at the Ready edge of any in-range access.
REQ-014 Ale and Req SHALL be ignored in WAIT and DONE; the address register and the captured write data SHALL be stable for the whole access.
REQ-015 When Req is held high continuously, a new access SHALL be accepted in the first IDLE cycle after DONE (back-to-back period of 2+WAIT_STATES cycles).
REQ-016 A read after a write to the same address SHALL return the written data.

Reset
REQ-017 On nReset=0 the block SHALL enter IDLE and set Ready=0, Fault=0, DataIn=16'h0000, the address register to 0 and the wait counter to 0, asynchronously.
REQ-018 A reset during WAIT or DONE SHALL abort the access; no array write SHALL occur and no Ready SHALL be issued.
REQ-019 Array contents SHALL NOT be reset.

Structure
REQ-020 The shared package sysbus_pkg SHALL hold:
- the FSM state enum typedef (IDLE, WAIT, DONE);
- the Rw encoding constants RW_READ=1 and RW_WRITE=0.
REQ-021 The storage SHALL be a sub-module mem_array: synchronous single-port RAM with parameter AW, a write enable, and read data registered on the clock.

Verification
REQ-022 The bench SHALL cover these directed scenarios (default parameters unless stated):
- Ale with 16'h0012, then Req with Rw=0 and 16'hBEEF, then Ale with 16'h0012, then Req with Rw=1 -> Ready 3 cycles after each Req edge; DataIn=16'hBEEF; Fault=0.
- WAIT_STATES=0, Req held high for reads at address 16'h0005 -> Ready every 2nd cycle.
- Ale with 16'h0100 (AW=8), then write 16'h1234 -> Fault=1 and array unchanged; a following read of 16'h0100 returns 16'h0000 with Fault=1; an in-range read then clears Fault.
- Ale and Req in the same cycle with 16'h0033 -> address=16'h0033, no Ready; a later Req alone reads address 16'h0033.
- nReset pulsed during WAIT of a write of 16'hAAAA to address 16'h0007 -> no Ready, outputs 0, address 16'h0007 not written.
- Ale and Req toggled during WAIT -> the address and the access are unaffected.
